// File: rtl/fifo_rd_status_if.sv
// Read-side bus of the dual-clock FIFO status block: read request, synchronized
// write pointer, threshold programming, and the registered status returned.
interface fifo_rd_status_if #(
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic          rd_en;
  logic [AW:0]   wptr_gray_sync;
  logic          ae_thresh_we;
  logic [AW:0]   ae_thresh_in;
  logic          underflow_clr;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr_gray;
  logic          rd_valid;
  logic          empty;
  logic          almost_empty;
  logic [AW:0]   rd_count;
  logic          underflow;

  modport master (
    output rd_en, wptr_gray_sync, ae_thresh_we, ae_thresh_in, underflow_clr,
    input  raddr, rptr_gray, rd_valid, empty, almost_empty, rd_count, underflow
  );

  modport slave (
    input  rd_en, wptr_gray_sync, ae_thresh_we, ae_thresh_in, underflow_clr,
    output raddr, rptr_gray, rd_valid, empty, almost_empty, rd_count, underflow
  );
endinterface

// File: rtl/fifo_rd_status.sv
// Read-domain pointer owner for the dual-clock FIFO: RAM read address, Gray pointer
// export, and registered empty / almost-empty / count / valid / underflow status.
module fifo_rd_status #(
  parameter int DEPTH    = 8,
  parameter int AE_RESET = 1
) (
  input  logic              clock,
  input  logic              reset,
  fifo_rd_status_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   rptr_bin;
  logic [AW:0]   rptr_gray_q;
  logic [AW-1:0] raddr_q;
  logic          rd_valid_q;
  logic          empty_q;
  logic          almost_empty_q;
  logic [AW:0]   rd_count_q;
  logic          underflow_q;
  logic [AW:0]   ae_thresh;

  logic          rd_fire;
  logic [AW:0]   rptr_next;
  logic [AW:0]   rptr_next_gray;
  logic [AW:0]   wbin;
  logic [AW:0]   count_next;

  // Gating on the registered empty keeps rd_fire free of the synchronizer path.
  assign rd_fire        = bus.rd_en & ~empty_q;
  assign rptr_next      = rptr_bin + {{AW{1'b0}}, rd_fire};
  assign rptr_next_gray = rptr_next ^ (rptr_next >> 1);
  assign count_next     = wbin - rptr_next;

  always_comb begin
    wbin = '0;
    for (int i = 0; i <= AW; i++) begin
      wbin[i] = ^(bus.wptr_gray_sync >> i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rptr_bin       <= '0;
      rptr_gray_q    <= '0;
      raddr_q        <= '0;
      rd_valid_q     <= 1'b0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      rd_count_q     <= '0;
      underflow_q    <= 1'b0;
      ae_thresh      <= (AW+1)'(AE_RESET);
    end else begin
      rptr_bin       <= rptr_next;
      rptr_gray_q    <= rptr_next_gray;
      raddr_q        <= rptr_next[AW-1:0];
      rd_valid_q     <= rd_fire;
      empty_q        <= (rptr_next_gray == bus.wptr_gray_sync);
      almost_empty_q <= (count_next <= ae_thresh);
      rd_count_q     <= count_next;
      if (bus.ae_thresh_we) begin
        ae_thresh <= bus.ae_thresh_in;
      end
      // A new underflow outranks a simultaneous clear so no event is lost.
      if (bus.rd_en && empty_q) begin
        underflow_q <= 1'b1;
      end else if (bus.underflow_clr) begin
        underflow_q <= 1'b0;
      end
    end
  end

  assign bus.raddr        = raddr_q;
  assign bus.rptr_gray    = rptr_gray_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.empty        = empty_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.rd_count     = rd_count_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_rd_status.sv
// Directed bench for fifo_rd_status at DEPTH=8: fill/drain, underflow, simultaneous
// read/write, pointer wrap, threshold programming and reset dominance.
module tb_fifo_rd_status;
  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   wb       = 0;
  int   rp       = 0;

  always #5 clock = ~clock;

  fifo_rd_status_if #(.DEPTH(8)) bus ();

  fifo_rd_status #(.DEPTH(8), .AE_RESET(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] gray(input int b);
    logic [3:0] x;
    x = b[3:0];
    return x ^ (x >> 1);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_w(input int b);
    wb = b & 15;
    bus.wptr_gray_sync = gray(wb);
  endtask

  task automatic st(input string tag, input int cnt, input int emp, input int ae, input int vld);
    chk({tag, ".count"}, 32'(bus.rd_count), 32'(cnt));
    chk({tag, ".empty"}, 32'(bus.empty), 32'(emp));
    chk({tag, ".ae"}, 32'(bus.almost_empty), 32'(ae));
    chk({tag, ".valid"}, 32'(bus.rd_valid), 32'(vld));
  endtask

  initial begin
    reset = 1'b1;
    bus.rd_en = 1'b0;
    bus.wptr_gray_sync = '0;
    bus.ae_thresh_we = 1'b0;
    bus.ae_thresh_in = '0;
    bus.underflow_clr = 1'b0;
    step();
    step();
    st("reset", 0, 1, 1, 0);
    chk("reset.gray", 32'(bus.rptr_gray), 0);
    chk("reset.raddr", 32'(bus.raddr), 0);
    chk("reset.uf", 32'(bus.underflow), 0);
    reset = 1'b0;
    step();
    st("idle", 0, 1, 1, 0);

    // Fill to 3 one Gray step at a time; count 1 sits exactly on threshold 1.
    set_w(1); step(); st("w1", 1, 0, 1, 0);
    set_w(2); step(); st("w2", 2, 0, 0, 0);
    set_w(3); step(); st("w3", 3, 0, 0, 0);

    bus.rd_en = 1'b1;
    step(); st("rd1", 2, 0, 0, 1); chk("rd1.raddr", 32'(bus.raddr), 1);
    step(); st("rd2", 1, 0, 1, 1); chk("rd2.raddr", 32'(bus.raddr), 2);
    step(); st("rd3", 0, 1, 1, 1); chk("rd3.raddr", 32'(bus.raddr), 3);
    chk("rd3.gray", 32'(bus.rptr_gray), 32'(gray(3)));

    // Reads held on an empty FIFO.
    step(); st("uf1", 0, 1, 1, 0); chk("uf1.uf", 32'(bus.underflow), 1);
    step(); st("uf2", 0, 1, 1, 0); chk("uf2.uf", 32'(bus.underflow), 1);
    chk("uf2.raddr", 32'(bus.raddr), 3);
    chk("uf2.gray", 32'(bus.rptr_gray), 32'(gray(3)));
    bus.rd_en = 1'b0; bus.underflow_clr = 1'b1;
    step(); chk("ufclr", 32'(bus.underflow), 0);
    bus.rd_en = 1'b1;
    step(); chk("uf_set_wins", 32'(bus.underflow), 1);
    bus.rd_en = 1'b0;
    step(); chk("ufclr2", 32'(bus.underflow), 0);
    bus.underflow_clr = 1'b0;

    // Count 1, read and write land together.
    set_w(4); step(); st("c1", 1, 0, 1, 0);
    bus.rd_en = 1'b1; set_w(5);
    step(); st("rw", 1, 0, 1, 1); chk("rw.raddr", 32'(bus.raddr), 4);
    bus.rd_en = 1'b0;

    // Threshold load is only seen by the edge after the load.
    bus.ae_thresh_we = 1'b1; bus.ae_thresh_in = 4'd0;
    step(); chk("th_load_edge", 32'(bus.almost_empty), 1);
    bus.ae_thresh_we = 1'b0;
    step(); chk("th0_ae", 32'(bus.almost_empty), 0);

    // 20 write/read pairs carry the read pointer through 15 -> 0.
    rp = 4;
    for (int k = 0; k < 20; k++) begin
      bus.rd_en = 1'b1;
      set_w(wb + 1);
      step();
      rp = (rp + 1) & 15;
      st("wrap", 1, 0, 0, 1);
      chk("wrap.raddr", 32'(bus.raddr), 32'(rp & 7));
      chk("wrap.gray", 32'(bus.rptr_gray), 32'(gray(rp)));
    end
    bus.rd_en = 1'b0;

    for (int k = 0; k < 7; k++) begin
      set_w(wb + 1);
      step();
    end
    st("full", 8, 0, 0, 0);
    chk("full.gray", 32'(bus.rptr_gray), 32'(gray(8)));
    chk("full.raddr", 32'(bus.raddr), 0);

    bus.ae_thresh_we = 1'b1; bus.ae_thresh_in = 4'd8;
    step();
    bus.ae_thresh_we = 1'b0;
    step(); chk("th8_ae", 32'(bus.almost_empty), 1);

    bus.rd_en = 1'b1;
    step(); step(); step();
    bus.rd_en = 1'b0;
    step(); st("c5", 5, 0, 1, 0);

    // Reset with a read pending must win.
    reset = 1'b1; bus.rd_en = 1'b1;
    step();
    st("rst2", 0, 1, 1, 0);
    chk("rst2.gray", 32'(bus.rptr_gray), 0);
    chk("rst2.raddr", 32'(bus.raddr), 0);
    chk("rst2.uf", 32'(bus.underflow), 0);
    reset = 1'b0; bus.rd_en = 1'b0;
    set_w(1); step(); st("post1", 1, 0, 1, 0);
    set_w(2); step(); st("post2", 2, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
